// File: rtl/accumulator_sequencer.sv
// Sequencer that clears an external accumulator, feeds it `count` operands and captures the sum.
// Optional FETCH stall abort is compiled in with `define ACC_SEQ_TIMEOUT_EN.
module accumulator_sequencer #(
  parameter int Word_Length    = 8,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       count,
  input  logic                   op_valid,
  input  logic [Word_Length-1:0] op_data,
  output logic                   op_ready,
  output logic                   acc_clear,
  output logic                   acc_enable,
  output logic [Word_Length-1:0] acc_data,
  output logic                   acc_read,
  input  logic [Word_Length-1:0] acc_result,
  output logic [Word_Length-1:0] result,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [2:0]             fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FETCH   = 3'd2,
    S_ACCUM   = 3'd3,
    S_READ    = 3'd4,
    S_CAPTURE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] remaining;
  logic             xfer;
  logic             abort;

  // Handshake: an operand moves only on a cycle where op_valid and op_ready are both high;
  // op_ready is a registered copy of "in FETCH", so it is never high in any other state.
  assign xfer      = op_ready && op_valid;
  assign fsm_state = state;

`ifdef ACC_SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall;

  // The abort fires on the TIMEOUT_CYCLES-th consecutive FETCH cycle without a transfer.
  assign abort = (state == S_FETCH) && !xfer &&
                 (stall == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= abort;
      if ((state == S_FETCH) && !xfer && !abort) stall <= stall + STALL_W'(1);
      else                                      stall <= '0;
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_CLEAR;
      S_CLEAR:   nxt = (remaining != '0) ? S_FETCH : S_READ;
      S_FETCH:   begin
        if (xfer)       nxt = S_ACCUM;
        else if (abort) nxt = S_DONE;
      end
      S_ACCUM:   nxt = (remaining != '0) ? S_FETCH : S_READ;
      S_READ:    nxt = S_CAPTURE;
      S_CAPTURE: nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Every output is a registered decode of the next state, so they all line up with `state`.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      op_ready   <= 1'b0;
      acc_clear  <= 1'b0;
      acc_enable <= 1'b0;
      acc_read   <= 1'b0;
      acc_data   <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt;
      op_ready   <= (nxt == S_FETCH);
      acc_clear  <= (nxt == S_CLEAR);
      acc_enable <= (nxt == S_ACCUM);
      acc_read   <= (nxt == S_READ) || (nxt == S_CAPTURE);
      busy       <= (nxt != S_IDLE);
      done       <= (nxt == S_DONE);
      if ((state == S_IDLE) && start) remaining <= count;
      else if (xfer)                  remaining <= remaining - CNT_W'(1);
      if (xfer) acc_data <= op_data;
      if (state == S_CAPTURE) result <= acc_result;
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer with a behavioural accumulator on acc_* signals.
module tb_accumulator_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] count = '0;
  logic       op_valid = 1'b0;
  logic [7:0] op_data = '0;
  logic       op_ready, acc_clear, acc_enable, acc_read, busy, done, timeout;
  logic [7:0] acc_data, acc_result, result;
  logic [2:0] fsm_state;
  logic [7:0] acc_sum = '0;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0, en_sum = 0, clr_cnt = 0, done_cnt = 0, xfer_cnt = 0, bad_ready = 0;

  accumulator_sequencer #(.Word_Length(8), .CNT_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .acc_clear(acc_clear), .acc_enable(acc_enable), .acc_data(acc_data),
    .acc_read(acc_read), .acc_result(acc_result), .result(result),
    .busy(busy), .done(done), .timeout(timeout), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (acc_clear)       acc_sum <= '0;
    else if (acc_enable) acc_sum <= acc_sum + acc_data;
  end
  assign acc_result = acc_sum;

  always @(negedge clk) begin
    if (!reset) begin
      if (acc_enable) begin en_cnt++; en_sum += int'(acc_data); end
      if (acc_clear) clr_cnt++;
      if (done) done_cnt++;
      if (op_valid && op_ready) xfer_cnt++;
      if (acc_enable && op_ready) bad_ready++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    en_cnt = 0; en_sum = 0; clr_cnt = 0; done_cnt = 0; xfer_cnt = 0; bad_ready = 0;
  endtask

  // mode 0: valid=1 data=3; 1: valid pattern 1,0,0,1 data=10+k; 2: valid=1 data=k+1 with
  // a second start at k=3; 3: valid=0; 4: valid=1 data=1. Returns in the done cycle.
  task automatic run_job(input logic [3:0] cnt, input int mode, input int budget, output int lat);
    int k;
    logic [3:0] pat;
    pat = 4'b1001;
    k = 0;
    lat = -1;
    count = cnt;
    start = 1'b1;
    while (k < budget) begin
      case (mode)
        0: begin op_valid = 1'b1; op_data = 8'd3; end
        1: begin op_valid = pat[k % 4]; op_data = 8'(10 + k); end
        2: begin op_valid = 1'b1; op_data = 8'(k + 1); end
        3: begin op_valid = 1'b0; op_data = 8'hAA; end
        default: begin op_valid = 1'b1; op_data = 8'd1; end
      endcase
      if (mode == 2 && k == 3) begin start = 1'b1; count = 4'd7; end
      tick();
      start = 1'b0;
      k++;
      if (done) begin lat = k; break; end
    end
    op_valid = 1'b0;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL job_no_done mode=%0d got=no done exp=done within %0d cycles", mode, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({op_ready, acc_clear, acc_enable, acc_read, busy, done, timeout} !== 7'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000000",
        {op_ready, acc_clear, acc_enable, acc_read, busy, done, timeout});
    end
    checks++;
    if (acc_data !== 8'd0 || result !== 8'd0 || fsm_state !== 3'd0) begin
      failures++; $display("FAIL reset_data got=%0d/%0d/%0d exp=0/0/0", acc_data, result, fsm_state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    clear_mon();
    run_job(4'd3, 0, 50, lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL basic_done_flags got=busy %b timeout %b exp=busy 1 timeout 0", busy, timeout); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_start_in_done got=busy %b done %b exp=0 0", busy, done); end
    checks++; if (result !== 8'd9) begin failures++; $display("FAIL basic_result got=%0d exp=9", result); end
    checks++; if (clr_cnt !== 1 || en_cnt !== 3 || en_sum !== 9) begin failures++; $display("FAIL basic_pulses got=clr %0d en %0d sum %0d exp=1 3 9", clr_cnt, en_cnt, en_sum); end
    checks++; if (acc_data !== 8'd3) begin failures++; $display("FAIL basic_acc_data_hold got=%0d exp=3", acc_data); end
    tick();
  endtask

  task automatic test_zero_count();
    int lat;
    clear_mon();
    run_job(4'd0, 0, 20, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL zero_latency got=%0d exp=4", lat); end
    tick();
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL zero_result got=%0d exp=0", result); end
    checks++; if (en_cnt !== 0 || clr_cnt !== 1 || xfer_cnt !== 0) begin failures++; $display("FAIL zero_pulses got=en %0d clr %0d xfer %0d exp=0 1 0", en_cnt, clr_cnt, xfer_cnt); end
    tick();
  endtask

  task automatic test_valid_toggle();
    int lat;
    clear_mon();
    run_job(4'd2, 1, 50, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL toggle_latency got=%0d exp=11", lat); end
    tick();
    checks++; if (xfer_cnt !== 2 || en_cnt !== 2) begin failures++; $display("FAIL toggle_counts got=xfer %0d en %0d exp=2 2", xfer_cnt, en_cnt); end
    checks++; if (en_sum !== 30 || result !== 8'd30) begin failures++; $display("FAIL toggle_sum got=sum %0d result %0d exp=30 30", en_sum, result); end
    checks++; if (bad_ready !== 0) begin failures++; $display("FAIL toggle_ready_in_accum got=%0d exp=0", bad_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_mon();
    run_job(4'd4, 2, 60, lat);
    checks++; if (lat !== 12) begin failures++; $display("FAIL b2b_latency got=%0d exp=12", lat); end
    tick();
    checks++; if (en_cnt !== 4 || clr_cnt !== 1) begin failures++; $display("FAIL b2b_pulses got=en %0d clr %0d exp=4 1", en_cnt, clr_cnt); end
    checks++; if (result !== 8'd24) begin failures++; $display("FAIL b2b_result got=%0d exp=24", result); end
    tick();
  endtask

  task automatic test_max_count();
    int lat;
    clear_mon();
    run_job(4'd15, 4, 80, lat);
    checks++; if (lat !== 34) begin failures++; $display("FAIL max_latency got=%0d exp=34", lat); end
    tick();
    checks++; if (en_cnt !== 15 || result !== 8'd15) begin failures++; $display("FAIL max_job got=en %0d result %0d exp=15 15", en_cnt, result); end
    tick();
  endtask

  task automatic test_timeout();
`ifdef ACC_SEQ_TIMEOUT_EN
    int lat;
    clear_mon();
    run_job(4'd3, 3, 60, lat);
    checks++; if (lat !== 18) begin failures++; $display("FAIL timeout_latency got=%0d exp=18", lat); end
    checks++; if (done !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL timeout_flags got=done %b timeout %b exp=1 1", done, timeout); end
    tick();
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=timeout %b busy %b exp=0 0", timeout, busy); end
    checks++; if (result !== 8'd15 || en_cnt !== 0) begin failures++; $display("FAIL timeout_result got=result %0d en %0d exp=15 0", result, en_cnt); end
`else
    clear_mon();
    count = 4'd3;
    start = 1'b1;
    op_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checks++; if (busy !== 1'b1 || op_ready !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL stall_wait got=busy %b ready %b timeout %b exp=1 1 0", busy, op_ready, timeout); end
    checks++; if (done_cnt !== 0 || result !== 8'd15) begin failures++; $display("FAIL stall_no_done got=done %0d result %0d exp=0 15", done_cnt, result); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
    tick();
  endtask

  task automatic test_reset_mid_job();
    int lat;
    clear_mon();
    count = 4'd5;
    start = 1'b1;
    op_valid = 1'b1;
    op_data = 8'd4;
    for (int k = 0; k < 5; k++) begin tick(); start = 1'b0; end
    checks++; if (acc_enable !== 1'b1 || fsm_state !== 3'd3) begin failures++; $display("FAIL midrst_in_accum got=en %b state %0d exp=1 3", acc_enable, fsm_state); end
    reset = 1'b1;
    tick();
    checks++;
    if ({op_ready, acc_clear, acc_enable, acc_read, busy, done, timeout} !== 7'b0 ||
        acc_data !== 8'd0 || result !== 8'd0) begin
      failures++; $display("FAIL midrst_outputs got=%b data %0d result %0d exp=0000000 0 0",
        {op_ready, acc_clear, acc_enable, acc_read, busy, done, timeout}, acc_data, result);
    end
    reset = 1'b0;
    clear_mon();
    for (int k = 0; k < 10; k++) tick();
    checks++; if (done_cnt !== 0 || en_cnt !== 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_aborted got=done %0d en %0d busy %b exp=0 0 0", done_cnt, en_cnt, busy); end
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || fsm_state !== 3'd0) begin failures++; $display("FAIL reset_over_start got=busy %b state %0d exp=0 0", busy, fsm_state); end
    clear_mon();
    run_job(4'd2, 0, 40, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL midrst_rerun_latency got=%0d exp=8", lat); end
    tick();
    checks++; if (result !== 8'd6 || en_cnt !== 2) begin failures++; $display("FAIL midrst_rerun_result got=result %0d en %0d exp=6 2", result, en_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_valid_toggle();
    test_back_to_back();
    test_max_count();
    test_timeout();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
